// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and constants for the iterative magnitude comparator.
//
// Contents:
//   DATA_WIDTH   - default ALU operand width
//   cmp_state_t  - comparator FSM state encoding
//   cmp_result_t - one-hot compare outcome {equal, lower, greater}
package seq_magnitude_comparator_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic equal;
    logic lower;
    logic greater;
  } cmp_result_t;

endpackage

// File: rtl/seq_magnitude_comparator_cmp_digit.sv
// Combinational unsigned compare of one DIGIT_W-bit operand slice.
//
// Ports:
//   a_dig  - digit of operand A
//   b_dig  - digit of operand B
//   res    - one-hot {equal, lower, greater} of a_dig against b_dig
module seq_magnitude_comparator_cmp_digit
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int DIGIT_W = 2
) (
  input  logic [DIGIT_W-1:0] a_dig,
  input  logic [DIGIT_W-1:0] b_dig,
  output cmp_result_t        res
);

  always_comb begin
    res         = '0;
    res.equal   = (a_dig == b_dig);
    res.lower   = (a_dig <  b_dig);
    res.greater = (a_dig >  b_dig);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Iterative MSB-first magnitude comparator with valid/ready handshakes.
// Operands are compared DIGIT_W bits per cycle and the walk stops at the
// first differing digit. Signed compares map both operands to offset
// binary at capture time, so the digit walk is always unsigned.
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid / in_ready  - operand handshake (a, b, in_signed)
//   out_valid / out_ready- result handshake
//   equal/lower/greater  - one-hot result, valid with out_valid
//   cycles               - digit cycles spent on this result
//   min_out / max_out    - original operands ordered (only when the
//                          CMP_MINMAX_EN macro is defined)
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH   = DATA_WIDTH,
  parameter int DIGIT_W = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_signed,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 equal,
  output logic                                 lower,
  output logic                                 greater,
  output logic [$clog2(WIDTH/DIGIT_W+1)-1:0]   cycles
`ifdef CMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0]                     min_out,
  output logic [WIDTH-1:0]                     max_out
`endif
);

  localparam int NUM_DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  cmp_state_t       state;
  cmp_result_t      res_r;
  cmp_result_t      dig_res;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  logic [DIGIT_W-1:0] a_dig [NUM_DIGITS];
  logic [DIGIT_W-1:0] b_dig [NUM_DIGITS];
  logic [DIGIT_W-1:0] a_sel;
  logic [DIGIT_W-1:0] b_sel;

`ifdef CMP_MINMAX_EN
  // Remembered mode lets the ordered outputs undo the offset-binary map.
  logic             sgn;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] b_orig;

  assign a_orig = sgn ? (a_r ^ MSB_MASK) : a_r;
  assign b_orig = sgn ? (b_r ^ MSB_MASK) : b_r;
`else
  // Ordered operand outputs disabled: no extra state is kept.
`endif

  // Split the captured operands into digits; idx selects the one under test.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      a_dig[i] = a_r[i*DIGIT_W +: DIGIT_W];
      b_dig[i] = b_r[i*DIGIT_W +: DIGIT_W];
    end
  end

  assign a_sel = a_dig[idx];
  assign b_sel = b_dig[idx];

  seq_magnitude_comparator_cmp_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_cmp_digit (
    .a_dig (a_sel),
    .b_dig (b_sel),
    .res   (dig_res)
  );

  assign equal   = res_r.equal;
  assign lower   = res_r.lower;
  assign greater = res_r.greater;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res_r     <= '0;
      cycles    <= '0;
      a_r       <= '0;
      b_r       <= '0;
      idx       <= '0;
      cnt       <= '0;
`ifdef CMP_MINMAX_EN
      sgn       <= 1'b0;
      min_out   <= '0;
      max_out   <= '0;
`endif
    end else begin
      case (state)
        // Capture stage: operands enter, signed values go offset-binary.
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_signed ? (a ^ MSB_MASK) : a;
            b_r      <= in_signed ? (b ^ MSB_MASK) : b;
            idx      <= IDX_W'(NUM_DIGITS - 1);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
`ifdef CMP_MINMAX_EN
            sgn      <= in_signed;
`endif
          end
        end

        // Digit walk: a differing digit, or the LSB digit, decides.
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (!dig_res.equal || idx == '0) begin
            // On the LSB digit with no difference dig_res is already equal.
            res_r  <= dig_res;
            cycles <= cnt + CNT_W'(1);
            state  <= DONE;
`ifdef CMP_MINMAX_EN
            min_out <= dig_res.greater ? b_orig : a_orig;
            max_out <= dig_res.lower   ? b_orig : a_orig;
`endif
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end

        // Result stage: out_valid follows one cycle after the decision and
        // holds until the consumer takes it.
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed and reference-model bench for seq_magnitude_comparator.
// Instance u8: WIDTH=8, DIGIT_W=2. Instance u16: WIDTH=16, DIGIT_W=4.
// Ordered outputs are checked only when CMP_MINMAX_EN is defined.
module tb_seq_magnitude_comparator;
  import seq_magnitude_comparator_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, s8, ov8, or8, eq8, lo8, gt8;
  logic [7:0] a8, b8;
  logic [2:0] cy8;
  logic [2:0] fl8;

  logic        iv16, ir16, s16, ov16, or16, eq16, lo16, gt16;
  logic [15:0] a16, b16;
  logic [2:0]  cy16;
  logic [2:0]  fl16;

`ifdef CMP_MINMAX_EN
  logic [7:0]  mn8, mx8;
  logic [15:0] mn16, mx16;
`endif

  assign fl8  = {eq8, lo8, gt8};
  assign fl16 = {eq16, lo16, gt16};

  int n_chk = 0;
  int n_bad = 0;

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT_W(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_signed(s8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8),
    .equal(eq8), .lower(lo8), .greater(gt8), .cycles(cy8)
`ifdef CMP_MINMAX_EN
    , .min_out(mn8), .max_out(mx8)
`endif
  );

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT_W(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_signed(s16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16),
    .equal(eq16), .lower(lo16), .greater(gt16), .cycles(cy16)
`ifdef CMP_MINMAX_EN
    , .min_out(mn16), .max_out(mx16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present an operand pair to u8 and wait (bounded) for out_valid.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                     input int exp_lat);
    int lat;
    @(negedge clk);
    chk("u8_in_ready", 32'(ir8), 32'd1);
    a8 = av; b8 = bv; s8 = sv; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("u8_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic consume8();
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk("u8_ov_drop", 32'(ov8), 32'd0);
    chk("u8_ir_back", 32'(ir8), 32'd1);
  endtask

  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic sv);
    int          lat;
    int          k;
    logic [15:0] ra, rb;
    logic        lt, eq;
    ra = sv ? (av ^ 16'h8000) : av;
    rb = sv ? (bv ^ 16'h8000) : bv;
    k = 4;
    for (int d = 0; d < 4; d++)
      if (ra[d*4 +: 4] != rb[d*4 +: 4]) k = 4 - d;
    eq = (av == bv);
    lt = sv ? ($signed(av) < $signed(bv)) : (av < bv);
    @(negedge clk);
    a16 = av; b16 = bv; s16 = sv; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("u16_latency", 32'(lat), 32'(k + 1));
    chk("u16_flags", 32'(fl16), 32'({eq, lt & ~eq, ~lt & ~eq}));
    chk("u16_cycles", 32'(cy16), 32'(k));
`ifdef CMP_MINMAX_EN
    chk("u16_min", 32'(mn16), 32'(eq ? av : (lt ? av : bv)));
    chk("u16_max", 32'(mx16), 32'(eq ? av : (lt ? bv : av)));
`endif
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    chk("u16_ov_drop", 32'(ov16), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1;
    iv8 = 1'b0; s8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
    iv16 = 1'b0; s16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
    #12;
    chk("rst_in_ready", 32'(ir8), 32'd1);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_flags", 32'(fl8), 32'd0);
    chk("rst_cycles", 32'(cy8), 32'd0);
    chk("rst_in_ready16", 32'(ir16), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // 0x80 vs 0x7F unsigned: MSB digit 10 > 01.
    op8(8'h80, 8'h7F, 1'b0, 2);
    chk("u_80_7f_flags", 32'(fl8), 32'b001);
    chk("u_80_7f_cycles", 32'(cy8), 32'd1);
    consume8();

    // Same operands signed: -128 < 127.
    op8(8'h80, 8'h7F, 1'b1, 2);
    chk("s_80_7f_flags", 32'(fl8), 32'b010);
    chk("s_80_7f_cycles", 32'(cy8), 32'd1);
    consume8();

    op8(8'h5A, 8'h5A, 1'b0, 5);
    chk("eq_5a_flags", 32'(fl8), 32'b100);
    chk("eq_5a_cycles", 32'(cy8), 32'd4);
    consume8();

    op8(8'h5A, 8'h5B, 1'b0, 5);
    chk("lsb_lt_flags", 32'(fl8), 32'b010);
    chk("lsb_lt_cycles", 32'(cy8), 32'd4);
    consume8();

    // 0x34 vs 0x24: first difference in digit 2.
    op8(8'h34, 8'h24, 1'b0, 3);
    chk("d2_gt_flags", 32'(fl8), 32'b001);
    chk("d2_gt_cycles", 32'(cy8), 32'd2);
    consume8();

    // Backpressure: result held 10 cycles, a stray in_valid is ignored.
    op8(8'h10, 8'h20, 1'b0, 3);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        a8 = 8'hFF; b8 = 8'h00; iv8 = 1'b1;
      end
      if (i == 7) iv8 = 1'b0;
      chk("bp_out_valid", 32'(ov8), 32'd1);
      chk("bp_flags", 32'(fl8), 32'b010);
      chk("bp_cycles", 32'(cy8), 32'd2);
      chk("bp_in_ready", 32'(ir8), 32'd0);
      @(negedge clk);
    end
    consume8();
    @(negedge clk);
    chk("bp_no_restart", 32'(ov8), 32'd0);
    chk("bp_idle_ready", 32'(ir8), 32'd1);
    chk("bp_flags_kept", 32'(fl8), 32'b010);

    // Reset two digit cycles into an all-equal compare.
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; s8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(ov8), 32'd0);
    chk("abort_flags", 32'(fl8), 32'd0);
    chk("abort_cycles", 32'(cy8), 32'd0);
    chk("abort_in_ready", 32'(ir8), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet", 32'(ov8), 32'd0);
    end

    // -1 vs 1 signed.
    op8(8'hFF, 8'h01, 1'b1, 2);
    chk("s_ff_01_flags", 32'(fl8), 32'b010);
    chk("s_ff_01_cycles", 32'(cy8), 32'd1);
    consume8();

    // 16-bit, 4-bit digits: -2 vs 3 signed, then reference-model pairs.
    op16(16'hFFFE, 16'h0003, 1'b1);
    chk("s16_lower", 32'(lo16), 32'd1);
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = {ra[15:8], 8'($urandom)};
        2:       rb = {ra[15:4], 4'($urandom)};
        default: rb = 16'($urandom);
      endcase
      op16(ra, rb, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, iterative magnitude comparator for the ALU datapath; generalises the fixed 8-bit combinational equal/lower/greater comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT_W bits per cycle, in signed or unsigned mode.
- Terminates early at the first differing digit.
- Input and output use valid/ready handshakes so the block can sit between ALU pipeline stages under backpressure.

Parameters:
- WIDTH, DATA_WIDTH (from CPU_package), operand width in bits; must be a multiple of DIGIT_W and ≥ DIGIT_W.
- DIGIT_W, 2, bits compared per cycle; 1 ≤ DIGIT_W ≤ WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- equal  output  1  A == B.
- lower  output  1  A < B.
- greater  output  1  A > B.
- cycles  output  $clog2(WIDTH/DIGIT_W+1)  number of digit cycles used for this result.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, equal=0, lower=0, greater=0, cycles=0.
  - Operand registers and digit index are cleared.
- NUM_DIGITS = WIDTH/DIGIT_W.
- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready, capture a, b and in_signed.
  - If in_signed=1, invert bit WIDTH-1 of both captured operands (offset-binary map), so all later comparison is unsigned.
  - Set digit index = NUM_DIGITS-1 and go to BUSY.
- State BUSY:
  - in_ready=0.
  - Each cycle, compare digit [idx*DIGIT_W +: DIGIT_W] of A and B, and increment the internal cycle counter.
  - Digits differ → register lower/greater (one-hot), equal=0, go to DONE.
  - Digits equal and idx==0 → register equal=1, go to DONE.
  - Otherwise decrement idx and stay in BUSY.
- State DONE:
  - out_valid=1.
  - equal/lower/greater/cycles stay stable until the handshake.
  - On out_ready, go to IDLE; flags stay at their last value, and out_valid drops next cycle.
  - in_ready=0 in DONE; there is no overlap of new input with a pending result.
- Latency:
  - Operands accepted at edge T; the k-th digit is compared during cycle T+k.
  - out_valid rises at edge T+k+1, where k = cycles, 1 ≤ k ≤ NUM_DIGITS.
  - Minimum latency is 2 edges (decision at MSB digit); maximum is NUM_DIGITS+1.
- Invariant: equal, lower and greater are exactly one-hot whenever out_valid=1.
- out_ready held high in DONE: result consumed in one cycle.
- out_ready low: DONE holds indefinitely. a/b changes during BUSY or DONE are ignored.
- in_valid asserted outside IDLE is ignored; the producer must hold it until in_ready.
- Reset asserted mid-BUSY or in DONE aborts the operation immediately; the pending result is discarded.
- DIGIT_W == WIDTH degenerates to a single-cycle compare (k=1 always).

Optional Feature:
- Macro: CMP_MINMAX_EN.
- When defined:
  - Extra outputs min_out and max_out, both WIDTH bits, with the original (un-remapped) operand values.
  - Registered together with the flags; valid with out_valid.
  - On equal, both outputs carry A.
  - Reset value 0.
- When undefined: the ports and registers do not exist; all other behaviour is identical.

Decomposition:
- CPU_package holds:
  - DATA_WIDTH.
  - cmp_state_t enum {IDLE, BUSY, DONE}.
  - cmp_result_t packed struct {equal, lower, greater}.
- One sub-module, cmp_digit:
  - Combinational DIGIT_W-bit slice compare producing cmp_result_t.
  - Instantiated once and muxed by idx.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- WIDTH=8, DIGIT_W=2, unsigned, a=0x80, b=0x7F → greater=1, cycles=1, out_valid 2 edges after accept.
- Same operands with in_signed=1 → lower=1, cycles=1.
- a=0x5A, b=0x5A unsigned → equal=1, cycles=4. a=0x5A, b=0x5B → lower=1, cycles=4.
- Result for a=0x10, b=0x20 with out_ready held low 10 cycles:
  - out_valid, flags and cycles stay stable and in_ready=0.
  - A new in_valid is ignored.
  - On release, IDLE is reached the next cycle.
- rst pulsed mid-BUSY (a=0x00, b=0x00, after 2 digit cycles) → all outputs 0, in_ready=1, no out_valid. The next op (0xFF vs 0x01 signed) yields lower=1.
- WIDTH=16, DIGIT_W=4, CMP_MINMAX_EN defined, signed, a=0xFFFE (-2), b=0x0003:
  - lower=1, min_out=0xFFFE, max_out=0x0003, cycles=1.
  - Randomised 1000-pair check against a reference `<`/`==` model.
